rom_reader: RTL and testbench

Burst read initiator for the synchronous-read ROM (1-cycle address-to-data latency, no enable). On a start command it walks `len_i` consecutive ROM addresses from `base_addr_i` and delivers the words as a valid/ready stream with a last marker. A 2-entry buffer absorbs the ROM latency, so the stream sustains one word per cycle and tolerates arbitrary backpressure without losing data. It sits between a ROM instance and any streaming consumer, such as a DMA, a serializer or a test pattern source.

---
 rtl/rom_reader_pkg.sv | 14 +
 rtl/rom_reader_fifo2.sv | 65 ++++++
 rtl/rom_reader.sv | 139 +++++++++++++
 tb/tb_rom_reader.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_reader_pkg.sv
// Shared types and constants for the ROM burst reader.
// The burst FSM states and the depth of the latency-absorbing buffer.
package rom_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } rom_reader_state_t;

    localparam int BUF_DEPTH = 2;

endpackage

// File: rtl/rom_reader_fifo2.sv
// Two-entry synchronous FIFO carrying {last, data} beats for the burst reader.
// The head entry is read straight out of a storage register.
module rom_reader_fifo2
    import rom_reader_pkg::*;
#(
    parameter int WIDTH = 9
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_data_o,
    output logic [1:0]       count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam logic [1:0] FULL_CNT = 2'(BUF_DEPTH);

    logic [WIDTH-1:0] mem_q [BUF_DEPTH];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic [1:0]       count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o      = (count_q == FULL_CNT);
    assign empty_o     = (count_q == 2'd0);
    assign count_o     = count_q;
    assign head_data_o = mem_q[rd_ptr_q];

    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_ok) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/rom_reader.sv
// Burst read initiator for a 1-cycle-latency synchronous ROM.
// Walks len_i addresses from base_addr_i and streams the words out with a last marker.
module rom_reader
    import rom_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [ADDR_WIDTH:0]   len_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ADDR_WIDTH-1:0] rom_addr_o,
    input  logic [DATA_WIDTH-1:0] rom_data_i,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_valid_o,
    output logic                  m_last_o,
    input  logic                  m_ready_i
);

    localparam logic [ADDR_WIDTH:0]   WL_ONE   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    // Stream handshake: a beat moves on a rising edge where m_valid_o and
    // m_ready_i are both high; an offered beat stays put until it moves.
    rom_reader_state_t         state_q, state_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [ADDR_WIDTH:0]       words_left_q, words_left_d;
    logic                      inflight_q, inflight_d;
    logic                      inflight_last_q, inflight_last_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;

    logic                      pop;
    logic                      issue;
    logic [2:0]                occupancy;
    logic [2:0]                limit;
    logic [DATA_WIDTH:0]       head;
    logic [1:0]                fifo_count;
    logic                      fifo_full;
    logic                      fifo_empty;

    rom_reader_fifo2 #(
        .WIDTH(DATA_WIDTH + 1)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (inflight_q),
        .push_data_i ({inflight_last_q, rom_data_i}),
        .pop_i       (pop),
        .head_data_o (head),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign m_valid_o  = ~fifo_empty;
    assign m_data_o   = head[DATA_WIDTH-1:0];
    assign m_last_o   = head[DATA_WIDTH] & ~fifo_empty;
    assign pop        = m_valid_o & m_ready_i;
    assign rom_addr_o = addr_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

    // Issue only while buffered plus in-flight words, after this cycle's pop, stay below two.
    assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q};
    assign limit     = 3'd2 + {2'b00, pop};
    assign issue     = (state_q == READ) && (words_left_q != '0) && (occupancy < limit);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            words_left_q    <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            words_left_q    <= words_left_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = (len_i != '0) ? READ : DONE;
                end
            end
            READ: begin
                if (issue && (words_left_q == WL_ONE)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Only this burst's words are buffered, so a lone popped entry is the last one.
                if (!inflight_q && (fifo_empty || ((fifo_count == 2'd1) && pop))) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        addr_d          = addr_q;
        words_left_d    = words_left_q;
        inflight_d      = issue;
        inflight_last_d = issue && (words_left_q == WL_ONE);
        busy_d          = (state_d != IDLE);
        done_d          = (state_d == DONE);

        if ((state_q == IDLE) && start_i && (len_i != '0)) begin
            addr_d       = base_addr_i;
            words_left_d = len_i;
        end

        // The final address is left on the bus rather than stepping past it.
        if (issue) begin
            words_left_d = words_left_q - WL_ONE;
            if (words_left_q != WL_ONE) begin
                addr_d = addr_q + ADDR_ONE;
            end
        end
    end

endmodule

// File: tb/tb_rom_reader.sv
// Self-checking bench for rom_reader: a behavioural synchronous ROM with ROM[i] = i ^ 8'hA5
// and a scoreboard queue of expected {last, data} beats filled when each burst is started.
module tb_rom_reader;

    localparam int DW = 8;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base = '0;
    logic [AW:0]   len = '0;
    logic          busy;
    logic          done;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_last;
    logic          m_ready = 1'b1;

    logic [DW-1:0] rom_mem [256];
    logic [DW:0]   exp_q[$];
    int            n_checks = 0;
    int            n_errors = 0;

    always #5 clk = ~clk;

    always_ff @(posedge clk) rom_data <= rom_mem[rom_addr];

    rom_reader #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .base_addr_i (base),
        .len_i       (len),
        .busy_o      (busy),
        .done_o      (done),
        .rom_addr_o  (rom_addr),
        .rom_data_i  (rom_data),
        .m_data_o    (m_data),
        .m_valid_o   (m_valid),
        .m_last_o    (m_last),
        .m_ready_i   (m_ready)
    );

    // Starts one burst and follows it cycle by cycle (cycle 1 = first cycle after the start edge)
    // until the cycle after done; mode 0 holds ready high, mode 1 randomises it with 5-cycle stalls.
    task automatic run_burst(input logic [AW-1:0] b, input logic [AW:0] n, input int mode,
                             input bit extra, output int first_cyc, output int last_cyc,
                             output int done_cyc);
        logic [AW-1:0] addr_before;
        logic [AW-1:0] a;
        logic [DW:0]   exp_w;
        logic [DW:0]   got_w;
        logic [DW:0]   held_w;
        bit            stalled;
        bit            finished;
        int            stall_left;
        first_cyc = -1;
        last_cyc  = -1;
        done_cyc  = -1;
        held_w    = '0;
        for (int i = 0; i < int'(n); i++) begin
            a = b + AW'(i);
            exp_q.push_back({(i == int'(n) - 1), a ^ 8'hA5});
        end
        @(posedge clk); #1;
        addr_before = rom_addr;
        start = 1'b1;
        base  = b;
        len   = n;
        @(posedge clk); #1;
        start   = 1'b0;
        base    = 8'h55;
        len     = 9'd3;
        m_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        stalled    = 1'b0;
        finished   = 1'b0;
        stall_left = 0;
        for (int cyc = 1; cyc <= 3000 && !finished; cyc++) begin
            @(negedge clk);
            got_w = {m_last, m_data};
            if (stalled) begin
                n_checks++;
                if (m_valid !== 1'b1 || got_w !== held_w) begin
                    n_errors++;
                    $display("FAIL stall_hold cyc %0d: valid=%b beat=%h, required valid=1 beat=%h",
                             cyc, m_valid, got_w, held_w);
                end
            end
            if (mode == 0 && n != 0 && cyc <= int'(n)) begin
                n_checks++;
                if (rom_addr !== b + AW'(cyc - 1)) begin
                    n_errors++;
                    $display("FAIL rom_addr cyc %0d: got %h, required %h", cyc, rom_addr,
                             b + AW'(cyc - 1));
                end
            end
            if (n == 0) begin
                n_checks++;
                if (rom_addr !== addr_before || m_valid !== 1'b0) begin
                    n_errors++;
                    $display("FAIL len0_quiet cyc %0d: addr=%h valid=%b, required addr=%h valid=0",
                             cyc, rom_addr, m_valid, addr_before);
                end
            end
            if (m_valid === 1'b1 && m_ready === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL beat_extra cyc %0d: got beat %h, required no beat", cyc, got_w);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (got_w !== exp_w) begin
                        n_errors++;
                        $display("FAIL beat cyc %0d: got last=%b data=%h, required last=%b data=%h",
                                 cyc, got_w[DW], got_w[DW-1:0], exp_w[DW], exp_w[DW-1:0]);
                    end
                end
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
            end
            stalled = (m_valid === 1'b1) && (m_ready === 1'b0);
            held_w  = got_w;
            if (done === 1'b1) begin
                done_cyc = cyc;
                finished = 1'b1;
                n_checks++;
                if (busy !== 1'b1) begin
                    n_errors++;
                    $display("FAIL done_busy cyc %0d: busy=%b, required 1", cyc, busy);
                end
            end
            @(posedge clk); #1;
            if (mode == 0) begin
                m_ready = 1'b1;
            end else if (stall_left > 0) begin
                m_ready = 1'b0;
                stall_left--;
            end else if ($urandom_range(0, 9) == 0) begin
                m_ready = 1'b0;
                stall_left = 4;
            end else begin
                m_ready = 1'($urandom_range(0, 1));
            end
            start = (extra && !finished) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        start = 1'b0;
        if (!finished) begin
            n_checks++;
            n_errors++;
            $display("FAIL done_timeout: done never seen, required within 3000 cycles");
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || m_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL idle_after_done: busy=%b done=%b valid=%b, required 0 0 0",
                     busy, done, m_valid);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL missing_beats: %0d expected beats never seen, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({busy, done, m_valid, m_last} !== 4'b0000 || rom_addr !== '0 || m_data !== '0) begin
            n_errors++;
            $display("FAIL reset_values: busy=%b done=%b valid=%b last=%b addr=%h data=%h, required all 0",
                     busy, done, m_valid, m_last, rom_addr, m_data);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_idle: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_basic();
        int f, l, d;
        run_burst(8'h10, 9'd4, 0, 1'b0, f, l, d);
        n_checks++;
        if (f != 3 || l != 6 || d != 7) begin
            n_errors++;
            $display("FAIL basic_timing: first=%0d last=%0d done=%0d, required 3 6 7", f, l, d);
        end
    endtask

    task automatic test_wrap();
        int f, l, d;
        run_burst(8'hFE, 9'd4, 0, 1'b0, f, l, d);
        n_checks++;
        if (f != 3 || l != 6 || d != 7) begin
            n_errors++;
            $display("FAIL wrap_timing: first=%0d last=%0d done=%0d, required 3 6 7", f, l, d);
        end
    endtask

    task automatic test_backpressure();
        int f, l, d;
        run_burst(8'h80, 9'd16, 1, 1'b0, f, l, d);
        n_checks++;
        if (l < 0 || d != l + 1) begin
            n_errors++;
            $display("FAIL bp_done: last=%0d done=%0d, required done = last + 1", l, d);
        end
    endtask

    task automatic test_len_zero();
        int f, l, d;
        run_burst(8'h77, 9'd0, 0, 1'b0, f, l, d);
        n_checks++;
        if (f != -1 || d != 1) begin
            n_errors++;
            $display("FAIL len0_timing: first=%0d done=%0d, required no beat (-1) and done 1", f, d);
        end
    endtask

    task automatic test_full_rom();
        int f, l, d;
        run_burst(8'h00, 9'd256, 0, 1'b1, f, l, d);
        n_checks++;
        if (f != 3 || l != 258 || d != 259) begin
            n_errors++;
            $display("FAIL full_timing: first=%0d last=%0d done=%0d, required 3 258 259", f, l, d);
        end
    endtask

    task automatic test_reset_mid_burst();
        int f, l, d;
        @(posedge clk); #1;
        m_ready = 1'b0;
        start   = 1'b1;
        base    = 8'h30;
        len     = 9'd8;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (m_valid !== 1'b1 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL mid_burst_buffered: valid=%b busy=%b, required 1 1", m_valid, busy);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy, done, m_valid, m_last} !== 4'b0000 || rom_addr !== '0 || m_data !== '0) begin
            n_errors++;
            $display("FAIL mid_reset_values: busy=%b done=%b valid=%b last=%b addr=%h data=%h, required all 0",
                     busy, done, m_valid, m_last, rom_addr, m_data);
        end
        run_burst(8'h40, 9'd2, 0, 1'b0, f, l, d);
        n_checks++;
        if (f != 3 || l != 4 || d != 5) begin
            n_errors++;
            $display("FAIL post_reset_timing: first=%0d last=%0d done=%0d, required 3 4 5", f, l, d);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom_mem[i] = 8'(i) ^ 8'hA5;
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_len_zero();
        test_full_rom();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
